sha256_stream_core: RTL and testbench

- Parametrised successor to the single-block SHA-256 engine: hashes messages of any number of pre-padded 512-bit blocks, chaining the intermediate hash between blocks.
- Rounds per clock are configurable to trade area for latency.
- Sits between the message padder/packer upstream and the hash consumer downstream; valid/ready handshakes on both sides.

---
 rtl/sha256_pkg.sv | 101 ++++++++++
 rtl/sha256_round.sv | 29 ++
 rtl/sha256_stream_core.sv | 182 ++++++++++++++++++
 tb/tb_sha256_stream_core.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: widths, round constants, IV, the six
// compression/schedule functions and the core's state encoding.
package sha256_pkg;

    localparam int WORD_W     = 32;
    localparam int HASH_W     = 256;
    localparam int BLOCK_W    = 512;
    localparam int NUM_ROUNDS = 64;

    typedef logic [WORD_W-1:0] word_t;

    // Eight chaining words, H0 in the least significant word.
    typedef logic [7:0][WORD_W-1:0] hash_words_t;

    // Working variables a..h of one compression round.
    typedef struct packed {
        word_t a;
        word_t b;
        word_t c;
        word_t d;
        word_t e;
        word_t f;
        word_t g;
        word_t h;
    } work_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_FINAL,
        ST_DONE
    } core_state_t;

    localparam word_t K_TABLE [0:NUM_ROUNDS-1] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Listed H7 first so that H0 lands in the least significant word.
    localparam hash_words_t IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    // Chaining words H0..H7 map onto working variables a..h.
    function automatic work_t words_to_work(input hash_words_t hw);
        work_t ws;
        ws.a = hw[0];
        ws.b = hw[1];
        ws.c = hw[2];
        ws.d = hw[3];
        ws.e = hw[4];
        ws.f = hw[5];
        ws.g = hw[6];
        ws.h = hw[7];
        return ws;
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round.
module sha256_round
    import sha256_pkg::*;
(
    input  work_t state_in,
    input  word_t w,
    input  word_t k,
    output work_t state_out
);

    word_t t1;
    word_t t2;

    // Standard round: two temporaries, then shift the working variables.
    always_comb begin
        t1 = state_in.h + big_sigma1(state_in.e) + ch(state_in.e, state_in.f, state_in.g) + k + w;
        t2 = big_sigma0(state_in.a) + maj(state_in.a, state_in.b, state_in.c);

        state_out.a = t1 + t2;
        state_out.b = state_in.a;
        state_out.c = state_in.b;
        state_out.d = state_in.c;
        state_out.e = state_in.d + t1;
        state_out.f = state_in.e;
        state_out.g = state_in.f;
        state_out.h = state_in.g;
    end

endmodule

// File: rtl/sha256_stream_core.sv
// Multi-block SHA-256 core: hashes a stream of pre-padded 512-bit blocks,
// chaining H between blocks, with ROUNDS_PER_CYCLE rounds per clock.
module sha256_stream_core
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
)
(
    input  logic                 clk_p,
    input  logic                 reset_p,
    input  logic [BLOCK_W-1:0]   message_p,
    input  logic                 message_first_p,
    input  logic                 message_last_p,
    input  logic                 message_valid_p,
    output logic                 message_ready_p,
    output logic [HASH_W-1:0]    hash_p,
    output logic                 hash_valid_p,
    input  logic                 hash_ready_p,
    output logic                 busy_p
);

    // Legal ROUNDS_PER_CYCLE values are 1, 2, 4, 8 and 16.
    localparam int         ROUND_CYCLES = NUM_ROUNDS / ROUNDS_PER_CYCLE;
    localparam int         EXT_WORDS    = 16 + ROUNDS_PER_CYCLE;
    localparam logic [5:0] LAST_CYCLE   = 6'(ROUND_CYCLES - 1);

    typedef logic [EXT_WORDS-1:0][WORD_W-1:0] ext_t;

    core_state_t          state_q;
    core_state_t          state_d;
    logic [5:0]           round_cnt_q;
    logic                 last_q;
    logic                 accept;
    hash_words_t          h_q;
    hash_words_t          h_sum;
    hash_words_t          chain_in;
    work_t                work_q;
    work_t                round_out;
    logic [15:0][WORD_W-1:0] w_q;
    ext_t                 ext_w;

    // Extends the 16-word window by ROUNDS_PER_CYCLE freshly expanded words;
    // entries [0 .. RPC-1] feed this cycle's rounds, [RPC .. RPC+15] are the
    // next window.
    function automatic ext_t expand_schedule(input logic [15:0][WORD_W-1:0] win);
        ext_t e;
        for (int i = 0; i < 16; i++) begin
            e[i] = win[i];
        end
        for (int i = 16; i < EXT_WORDS; i++) begin
            e[i] = small_sigma1(e[i-2]) + e[i-7] + small_sigma0(e[i-15]) + e[i-16];
        end
        return e;
    endfunction

    assign ext_w = expand_schedule(w_q);

    // Chain of round instances; each stage has its own signals so the
    // combinational path is a plain feed-forward chain.
    for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_round
        work_t      stage_in;
        work_t      stage_out;
        logic [5:0] k_idx;

        if (j == 0) begin : g_head
            assign stage_in = work_q;
        end else begin : g_link
            assign stage_in = g_round[j-1].stage_out;
        end

        assign k_idx = 6'(int'(round_cnt_q) * ROUNDS_PER_CYCLE + j);

        sha256_round u_round (
            .state_in  (stage_in),
            .w         (ext_w[j]),
            .k         (K_TABLE[k_idx]),
            .state_out (stage_out)
        );
    end

    assign round_out = g_round[ROUNDS_PER_CYCLE-1].stage_out;

    // Chaining value for a newly accepted block, and the end-of-block sum.
    always_comb begin
        chain_in = message_first_p ? IV : h_q;
        h_sum[0] = h_q[0] + work_q.a;
        h_sum[1] = h_q[1] + work_q.b;
        h_sum[2] = h_q[2] + work_q.c;
        h_sum[3] = h_q[3] + work_q.d;
        h_sum[4] = h_q[4] + work_q.e;
        h_sum[5] = h_q[5] + work_q.f;
        h_sum[6] = h_q[6] + work_q.g;
        h_sum[7] = h_q[7] + work_q.h;
    end

    // State register.
    always_ff @(posedge clk_p) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset_p) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and handshake outputs, all decoded from the state.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
        state_d         = state_q;
        accept          = 1'b0;
        message_ready_p = 1'b0;
        hash_valid_p    = 1'b0;
        busy_p          = 1'b1;
        case (state_q)
            ST_IDLE: begin
                message_ready_p = 1'b1;
                busy_p          = 1'b0;
                if (message_valid_p) begin
                    accept  = 1'b1;
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (round_cnt_q == LAST_CYCLE) begin
                    state_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                state_d = last_q ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
                hash_valid_p = 1'b1;
                if (hash_ready_p) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers: round counter, last flag, chaining value, digest.
    always_ff @(posedge clk_p) begin
        if (reset_p) begin
            round_cnt_q <= '0;
            last_q      <= 1'b0;
            h_q         <= '0;
            hash_p      <= '0;
        end else begin
            if (accept) begin
                round_cnt_q <= '0;
                last_q      <= message_last_p;
                h_q         <= chain_in;
            end else if (state_q == ST_ROUND) begin
                round_cnt_q <= round_cnt_q + 6'd1;
            end

            if (state_q == ST_FINAL) begin
                h_q <= h_sum;
                if (last_q) begin
                    hash_p <= h_sum;
                end
            end
        end
    end

    // Datapath: message window and working variables.
    always_ff @(posedge clk_p) begin
        // NOTE: W window and a..h carry no reset; both are reloaded on every accept before they are read.
        if (accept) begin
            w_q    <= message_p;
            work_q <= words_to_work(chain_in);
        end else if (state_q == ST_ROUND) begin
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= ext_w[i + ROUNDS_PER_CYCLE];
            end
            work_q <= round_out;
        end
    end

endmodule

// File: tb/tb_sha256_stream_core.sv
// Self-checking bench for sha256_stream_core: one instance with one round
// per clock and one with sixteen, checked against a plain SHA-256 model.
module tb_sha256_stream_core;

    localparam logic [31:0] TB_K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] TB_IV = {32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
                                      32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

    // Published digests, H7 first so H0 sits in the low word.
    localparam logic [255:0] ABC_DIGEST  = {32'hf20015ad, 32'hb410ff61, 32'h96177a9c, 32'hb00361a3,
                                            32'h5dae2223, 32'h414140de, 32'h8f01cfea, 32'hba7816bf};
    localparam logic [255:0] ABCD_DIGEST = {32'h6f031589, 32'ha3e16193, 32'h23b9217d, 32'h209c8978,
                                            32'hf289579d, 32'h13b845fc, 32'hd4e6338d, 32'h88d4266f};
    localparam logic [255:0] NQ_DIGEST   = {32'h19db06c1, 32'hf6ecedd4, 32'h64ff2167, 32'ha33ce459,
                                            32'h0c3e6039, 32'he5c02693, 32'hd20638b8, 32'h248d6a61};

    localparam logic [31:0] NQ_WORDS [0:15] = '{
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [511:0] message = '0;
    logic         msg_first = 1'b0;
    logic         msg_last = 1'b0;
    logic         msg_valid [2];
    logic         hash_ready [2];
    logic         msg_ready [2];
    logic         hash_valid [2];
    logic         busy [2];
    logic [255:0] hash [2];
    logic [255:0] model_h [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sha256_stream_core #(.ROUNDS_PER_CYCLE(1)) u_dut_rpc1 (
        .clk_p           (clk),
        .reset_p         (reset),
        .message_p       (message),
        .message_first_p (msg_first),
        .message_last_p  (msg_last),
        .message_valid_p (msg_valid[0]),
        .message_ready_p (msg_ready[0]),
        .hash_p          (hash[0]),
        .hash_valid_p    (hash_valid[0]),
        .hash_ready_p    (hash_ready[0]),
        .busy_p          (busy[0])
    );

    sha256_stream_core #(.ROUNDS_PER_CYCLE(16)) u_dut_rpc16 (
        .clk_p           (clk),
        .reset_p         (reset),
        .message_p       (message),
        .message_first_p (msg_first),
        .message_last_p  (msg_last),
        .message_valid_p (msg_valid[1]),
        .message_ready_p (msg_ready[1]),
        .hash_p          (hash[1]),
        .hash_valid_p    (hash_valid[1]),
        .hash_ready_p    (hash_ready[1]),
        .busy_p          (busy[1])
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Clock edges from accept to hash_valid (and to ready on a chained block).
    function automatic int latency_edges(input int d);
        return (d == 0) ? 65 : 5;
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference SHA-256 compression of one block on top of chaining value h_in.
    function automatic logic [255:0] model_compress(input logic [255:0] h_in, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  s0, s1, t1, t2;
        logic [255:0] h_out;
        for (int t = 0; t < 16; t++) w[t] = blk[32*t +: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
        for (int i = 0; i < 8; i++) v[i] = h_in[32*i +: 32];
        for (int t = 0; t < 64; t++) begin
            s1 = rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25);
            s0 = rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22);
            t1 = v[7] + s1 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + TB_K[t] + w[t];
            t2 = s0 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) h_out[32*i +: 32] = h_in[32*i +: 32] + v[i];
        return h_out;
    endfunction

    function automatic logic [511:0] random_block();
        logic [511:0] b;
        for (int t = 0; t < 16; t++) b[32*t +: 32] = $urandom();
        return b;
    endfunction

    // Called at a falling edge. Presents a block to DUT d, waits (bounded)
    // for ready, lets one rising edge accept it and returns at the falling
    // edge after the accept edge with the inputs scrambled.
    task automatic send_block(input int d, input logic [511:0] blk, input logic first, input logic last,
                              output int n_wait, output logic saw_valid);
        message      = blk;
        msg_first    = first;
        msg_last     = last;
        msg_valid[d] = 1'b1;
        n_wait       = 0;
        saw_valid    = 1'b0;
        while (!msg_ready[d] && n_wait < 400) begin
            @(negedge clk);
            n_wait++;
            if (hash_valid[d]) saw_valid = 1'b1;
        end
        if (!msg_ready[d]) begin
            check("accept_timeout", 256'(0), 256'(1));
            msg_valid[d] = 1'b0;
            return;
        end
        @(negedge clk);
        msg_valid[d] = 1'b0;
        model_h[d]   = model_compress(first ? TB_IV : model_h[d], blk);
        message      = random_block();
        msg_first    = 1'(~first);
        msg_last     = 1'(~last);
    endtask

    task automatic wait_digest(input int d, output int lat);
        lat = 0;
        while (!hash_valid[d] && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        if (!hash_valid[d]) check("digest_timeout", 256'(0), 256'(1));
    endtask

    task automatic take_digest(input int d, input string tag);
        hash_ready[d] = 1'b1;
        @(negedge clk);
        hash_ready[d] = 1'b0;
        check({tag, "_valid_drop"}, 256'(hash_valid[d]), 256'(0));
        check({tag, "_ready_back"}, 256'(msg_ready[d]), 256'(1));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_h[0] = '0;
        model_h[1] = '0;
    endtask

    task automatic check_reset_state(input int d);
        check("rst_ready", 256'(msg_ready[d]), 256'(1));
        check("rst_valid", 256'(hash_valid[d]), 256'(0));
        check("rst_hash", hash[d], 256'(0));
        check("rst_busy", 256'(busy[d]), 256'(0));
    endtask

    initial begin
        logic [511:0] abc_blk, abcd_blk, nq_blk1, nq_blk2, blk;
        logic         sv, first;
        int           n, lat, nb;

        abc_blk = '0;
        abc_blk[31:0] = 32'h61626380;
        abc_blk[511:480] = 32'h00000018;
        abcd_blk = '0;
        abcd_blk[31:0] = 32'h61626364;
        abcd_blk[63:32] = 32'h80000000;
        abcd_blk[511:480] = 32'h00000020;
        for (int t = 0; t < 16; t++) nq_blk1[32*t +: 32] = NQ_WORDS[t];
        nq_blk2 = '0;
        nq_blk2[511:480] = 32'h000001c0;

        for (int d = 0; d < 2; d++) begin
            msg_valid[d]  = 1'b0;
            hash_ready[d] = 1'b0;
            model_h[d]    = '0;
        end

        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_reset_state(0);
        check_reset_state(1);

        // "abc" on the one-round-per-clock core, then a 20-cycle stall in DONE
        // with a new block waiting.
        send_block(0, abc_blk, 1'b1, 1'b1, n, sv);
        check("abc_busy", 256'(busy[0]), 256'(1));
        check("abc_ready_low", 256'(msg_ready[0]), 256'(0));
        wait_digest(0, lat);
        check("abc_latency", 256'(lat), 256'(latency_edges(0)));
        check("abc_digest", hash[0], ABC_DIGEST);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 5) begin
                message      = abcd_blk;
                msg_first    = 1'b1;
                msg_last     = 1'b1;
                msg_valid[0] = 1'b1;
            end
            check("stall_valid", 256'(hash_valid[0]), 256'(1));
            check("stall_hash", hash[0], ABC_DIGEST);
            check("stall_ready", 256'(msg_ready[0]), 256'(0));
        end
        hash_ready[0] = 1'b1;
        @(negedge clk);
        hash_ready[0] = 1'b0;
        check("stall_release_valid", 256'(hash_valid[0]), 256'(0));
        check("stall_release_ready", 256'(msg_ready[0]), 256'(1));
        check("stall_release_idle", 256'(busy[0]), 256'(0));
        check("stall_hash_kept", hash[0], ABC_DIGEST);
        @(negedge clk);
        msg_valid[0] = 1'b0;
        model_h[0] = model_compress(TB_IV, abcd_blk);
        check("late_accept_busy", 256'(busy[0]), 256'(1));
        wait_digest(0, lat);
        check("abcd1_latency", 256'(lat), 256'(latency_edges(0)));
        check("abcd1_digest", hash[0], ABCD_DIGEST);
        take_digest(0, "abcd1");

        // "abcd" on the sixteen-rounds-per-clock core.
        send_block(1, abcd_blk, 1'b1, 1'b1, n, sv);
        wait_digest(1, lat);
        check("abcd16_latency", 256'(lat), 256'(latency_edges(1)));
        check("abcd16_digest", hash[1], ABCD_DIGEST);
        take_digest(1, "abcd16");

        // Two-block message, second block offered back-to-back.
        send_block(0, nq_blk1, 1'b1, 1'b0, n, sv);
        send_block(0, nq_blk2, 1'b0, 1'b1, n, sv);
        check("nq_no_valid_mid", 256'(sv), 256'(0));
        check("nq_ready_return", 256'(n), 256'(latency_edges(0)));
        check("nq_hash_held", hash[0], ABCD_DIGEST);
        wait_digest(0, lat);
        check("nq_digest", hash[0], NQ_DIGEST);
        take_digest(0, "nq");

        // Reset around round 30 of "abc", then a clean "abc".
        send_block(0, abc_blk, 1'b1, 1'b1, n, sv);
        repeat (30) @(negedge clk);
        check("mid_busy", 256'(busy[0]), 256'(1));
        do_reset();
        check_reset_state(0);
        send_block(0, abc_blk, 1'b1, 1'b1, n, sv);
        wait_digest(0, lat);
        check("abc_after_rst_latency", 256'(lat), 256'(latency_edges(0)));
        check("abc_after_rst_digest", hash[0], ABC_DIGEST);
        take_digest(0, "abc_rst");

        // Continuation block straight after reset chains from H=0.
        blk = random_block();
        send_block(1, blk, 1'b0, 1'b1, n, sv);
        wait_digest(1, lat);
        check("cont_from_zero", hash[1], model_compress(256'(0), blk));
        take_digest(1, "cont");

        // Random messages of 1..3 blocks on both cores; some messages chain
        // from the previous result instead of the IV.
        for (int d = 0; d < 2; d++) begin
            for (int m = 0; m < 10; m++) begin
                nb = $urandom_range(1, 3);
                for (int b = 0; b < nb; b++) begin
                    blk = random_block();
                    first = (b == 0) && ($urandom_range(0, 4) != 0);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    send_block(d, blk, first, (b == nb - 1), n, sv);
                    if (b > 0) check("rand_no_valid_mid", 256'(sv), 256'(0));
                end
                wait_digest(d, lat);
                check("rand_latency", 256'(lat), 256'(latency_edges(d)));
                check("rand_digest", hash[d], model_h[d]);
                repeat ($urandom_range(0, 4)) @(negedge clk);
                check("rand_hold", hash[d], model_h[d]);
                take_digest(d, "rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
